// File: rtl/pipelined_barrel_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Purpose  : Shared types and elaboration helpers for the pipelined barrel
//            shifter: the shift-operation encoding and the functions that
//            split the log2(XLEN) shift levels across the pipeline stages.
// Contents : shift_op_e    - 2-bit shift operation (SLL/SRL/SRA/ROR)
//            shamt_w()     - shift-amount width for a given operand width
//            stage_levels()- number of shift levels placed in a stage
//            stage_first() - index of the first shift level in a stage
// Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_e;

    function automatic int shamt_w(input int xlen);
        return $clog2(xlen);
    endfunction

    // Levels are shared evenly; the first (shw % stages) stages take one extra.
    function automatic int stage_levels(input int shw, input int stages, input int s);
        return (shw / stages) + ((s < (shw % stages)) ? 1 : 0);
    endfunction

    function automatic int stage_first(input int shw, input int stages, input int s);
        return (s * (shw / stages)) + ((s < (shw % stages)) ? s : (shw % stages));
    endfunction

endpackage : shift_pkg
`default_nettype wire

// File: rtl/pipelined_barrel_shifter_level.sv
`default_nettype none
// ============================================================================
// Module   : shifter_level
// Purpose  : One combinational level of the barrel shifter. When enabled it
//            shifts the operand by the fixed distance DIST using the fill
//            rule of the selected operation; otherwise it passes data through.
// Ports    : i_data [XLEN] operand in
//            i_op          shift operation
//            i_en          apply this level (shift-amount bit for DIST)
//            o_data [XLEN] operand out
// Revision : 1.0 - initial release
// ============================================================================
module shifter_level
    import shift_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int DIST = 1
) (
    input  logic [XLEN-1:0] i_data,
    input  shift_op_e       i_op,
    input  logic            i_en,
    output logic [XLEN-1:0] o_data
);

    always_comb begin
        o_data = i_data;
        if (i_en) begin
            case (i_op)
                SHIFT_SLL: o_data = i_data << DIST;
                SHIFT_SRL: o_data = i_data >> DIST;
                SHIFT_SRA: o_data = $unsigned($signed(i_data) >>> DIST);
                SHIFT_ROR: o_data = {i_data[DIST-1:0], i_data[XLEN-1:DIST]};
                default:   o_data = i_data;
            endcase
        end
    end

endmodule : shifter_level
`default_nettype wire

// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_barrel_shifter
// Purpose  : Log-depth SLL/SRL/SRA/ROR barrel shifter split over PIPE_STAGES
//            register stages with valid/ready handshake, global stall,
//            flush and a pass-through tag.
// Ports    : clk_i, rst_ni (sync, active low), flush_i
//            in_valid_i / in_ready_o, in_op_i, rs1_i, rs2_i, in_tag_i
//            out_valid_o / out_ready_i, rd_o, out_tag_o
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter
    import shift_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       in_op_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  rd_o,
    output logic [TAG_W-1:0] out_tag_o
);

    localparam int c_shw = shamt_w(XLEN);

    // Index s is the input of stage s; index PIPE_STAGES is the output bank.
    logic             w_stg_valid [0:PIPE_STAGES];
    logic [XLEN-1:0]  w_stg_data  [0:PIPE_STAGES];
    logic [TAG_W-1:0] w_stg_tag   [0:PIPE_STAGES];
    shift_op_e        w_stg_op    [0:PIPE_STAGES-1];
    logic [c_shw-1:0] w_stg_shamt [0:PIPE_STAGES-1];

    logic             w_advance;
    logic [XLEN-c_shw-1:0] w_unused_rs2;

    // Whole pipe moves together; it only stalls when the result is not taken.
    assign w_advance  = !out_valid_o || out_ready_i;
    assign in_ready_o = w_advance && rst_ni;

    // Upper shift-amount bits carry no meaning for an XLEN-bit shift.
    assign w_unused_rs2 = rs2_i[XLEN-1:c_shw];

    assign w_stg_valid[0] = in_valid_i && in_ready_o;
    assign w_stg_data[0]  = rs1_i;
    assign w_stg_tag[0]   = in_tag_i;
    assign w_stg_op[0]    = shift_op_e'(in_op_i);
    assign w_stg_shamt[0] = rs2_i[c_shw-1:0];

    assign out_valid_o = w_stg_valid[PIPE_STAGES];
    assign rd_o        = w_stg_data[PIPE_STAGES];
    assign out_tag_o   = w_stg_tag[PIPE_STAGES];

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        localparam int c_first = stage_first(c_shw, PIPE_STAGES, s);
        localparam int c_nlvl  = stage_levels(c_shw, PIPE_STAGES, s);

        logic [XLEN-1:0]  w_chain [0:c_nlvl];
        logic             w_load;
        logic             r_valid_q, w_valid_d;
        logic [XLEN-1:0]  r_data_q,  w_data_d;
        logic [TAG_W-1:0] r_tag_q,   w_tag_d;

        assign w_chain[0] = w_stg_data[s];

        for (genvar j = 0; j < c_nlvl; j++) begin : g_level
            shifter_level #(
                .XLEN (XLEN),
                .DIST (1 << (c_first + j))
            ) u_level (
                .i_data (w_chain[j]),
                .i_op   (w_stg_op[s]),
                .i_en   (w_stg_shamt[s][c_first+j]),
                .o_data (w_chain[j+1])
            );
        end

        // Payload only moves when a real op enters the stage.
        assign w_load = w_advance && w_stg_valid[s];

        always_comb begin
            w_valid_d = r_valid_q;
            w_data_d  = r_data_q;
            w_tag_d   = r_tag_q;
            if (flush_i) begin
                w_valid_d = 1'b0;
            end else if (w_advance) begin
                w_valid_d = w_stg_valid[s];
            end
            if (w_load) begin
                w_data_d = w_chain[c_nlvl];
                w_tag_d  = w_stg_tag[s];
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_valid_q <= 1'b0;
                r_data_q  <= '0;
                r_tag_q   <= '0;
            end else begin
                r_valid_q <= w_valid_d;
                r_data_q  <= w_data_d;
                r_tag_q   <= w_tag_d;
            end
        end

        assign w_stg_valid[s+1] = r_valid_q;
        assign w_stg_data[s+1]  = r_data_q;
        assign w_stg_tag[s+1]   = r_tag_q;

        // Operation and shift amount are only needed by later stages.
        if (s < PIPE_STAGES - 1) begin : g_fwd
            shift_op_e        r_op_q,    w_op_d;
            logic [c_shw-1:0] r_shamt_q, w_shamt_d;

            always_comb begin
                w_op_d    = r_op_q;
                w_shamt_d = r_shamt_q;
                if (w_load) begin
                    w_op_d    = w_stg_op[s];
                    w_shamt_d = w_stg_shamt[s];
                end
            end

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    r_op_q    <= SHIFT_SLL;
                    r_shamt_q <= '0;
                end else begin
                    r_op_q    <= w_op_d;
                    r_shamt_q <= w_shamt_d;
                end
            end

            assign w_stg_op[s+1]    = r_op_q;
            assign w_stg_shamt[s+1] = r_shamt_q;
        end
    end

endmodule : pipelined_barrel_shifter
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_barrel_shifter
// Purpose  : Self-checking bench for pipelined_barrel_shifter (XLEN=32,
//            PIPE_STAGES=2, TAG_W=5). Inputs change on the falling edge,
//            outputs are observed on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_barrel_shifter;

    localparam int c_p = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rd;
    logic [4:0]  out_tag;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(
        .XLEN        (32),
        .PIPE_STAGES (c_p),
        .TAG_W       (5)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_op_i     (in_op),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .in_tag_i    (in_tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .rd_o        (rd),
        .out_tag_o   (out_tag)
    );

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int                 sh;
        logic signed [31:0] sa;
        logic [31:0]        r;
        sh = int'(b[4:0]);
        sa = a;
        case (op)
            2'd0:    r = a << sh;
            2'd1:    r = a >> sh;
            2'd2:    r = sa >>> sh;
            default: r = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
        endcase
        return r;
    endfunction

    // Issues one op into an idle pipe and waits (bounded) for its result.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output logic [31:0] res,
                         output logic [4:0] t, output int lat);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = op;
        rs1       = a;
        rs2       = b;
        in_tag    = tag;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = rd;
        t   = out_tag;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_rd got %h want 00000000", rd); end
        n_vec++; if (out_tag !== 5'h0) begin n_err++; $display("FAIL reset_tag got %h want 00", out_tag); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_fill;
        vec_t        v [9];
        logic [31:0] res;
        logic [4:0]  t;
        int          lat;
        v[0] = '{2'd2, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF};
        v[1] = '{2'd1, 32'h8000_0000, 32'd31,        32'h0000_0001};
        v[2] = '{2'd0, 32'h0000_0001, 32'd31,        32'h8000_0000};
        v[3] = '{2'd3, 32'h0000_0001, 32'd1,         32'h8000_0000};
        v[4] = '{2'd1, 32'hFFFF_FFFF, 32'h25,        32'h07FF_FFFF};
        v[5] = '{2'd2, 32'h7000_0000, 32'd4,         32'h0700_0000};
        v[6] = '{2'd3, 32'h1234_5678, 32'd8,         32'h7812_3456};
        v[7] = '{2'd0, 32'h0000_00FF, 32'd4,         32'h0000_0FF0};
        v[8] = '{2'd2, 32'hF000_0000, 32'hFFFF_FFE4, 32'hFF00_0000};
        for (int i = 0; i < 9; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, 5'(i + 3), res, t, lat);
            n_vec++; if (res !== v[i].exp) begin n_err++; $display("FAIL fill_rd[%0d] got %h want %h", i, res, v[i].exp); end
            n_vec++; if (t !== 5'(i + 3)) begin n_err++; $display("FAIL fill_tag[%0d] got %0d want %0d", i, t, i + 3); end
            n_vec++; if (lat != c_p) begin n_err++; $display("FAIL fill_latency[%0d] got %0d want %0d", i, lat, c_p); end
        end
    endtask

    task automatic test_zero_shamt;
        logic [31:0] res;
        logic [4:0]  t;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            do_op(2'(i % 4), 32'hA5C3_0F96, (i < 4) ? 32'h0 : 32'h40, 5'(i), res, t, lat);
            n_vec++; if (res !== 32'hA5C3_0F96) begin n_err++; $display("FAIL zero_shamt[%0d] got %h want a5c30f96", i, res); end
        end
    endtask

    task automatic test_back_to_back;
        int          got = 0;
        logic [31:0] a [8];
        logic [31:0] b [8];
        for (int j = 0; j < 8; j++) begin
            a[j] = 32'hC001_D00D ^ (32'(j) << 7);
            b[j] = 32'(j * 3 + 1);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8 + c_p + 3; k++) begin
            if (out_valid) begin
                if (got < 8) begin
                    n_vec++; if (rd !== model(2'(got % 4), a[got], b[got])) begin n_err++;
                        $display("FAIL b2b_rd[%0d] got %h want %h", got, rd, model(2'(got % 4), a[got], b[got])); end
                    n_vec++; if (out_tag !== 5'(got)) begin n_err++; $display("FAIL b2b_tag[%0d] got %0d want %0d", got, out_tag, got); end
                    n_vec++; if (k != got + c_p) begin n_err++; $display("FAIL b2b_cycle[%0d] got %0d want %0d", got, k, got + c_p); end
                end
                got++;
            end
            if (k < 8) begin
                in_valid = 1'b1;
                in_op    = 2'(k % 4);
                rs1      = a[k];
                rs2      = b[k];
                in_tag   = 5'(k);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_vec++; if (got != 8) begin n_err++; $display("FAIL b2b_count got %0d want 8", got); end
    endtask

    task automatic test_stall;
        logic [31:0] q_rd [$];
        logic [4:0]  q_tag [$];
        int          sent = 0;
        int          recv = 0;
        logic        held = 1'b0;
        logic [31:0] prev_rd = '0;
        logic [4:0]  prev_tag = '0;
        logic [31:0] er;
        logic [4:0]  et;
        for (int c = 0; c < 60 && recv < 12; c++) begin
            out_ready = !(c >= 3 && c < 8);
            in_valid  = (sent < 12);
            in_op     = 2'(sent % 4);
            rs1       = 32'h8F0F_1234 + 32'(sent * 32'h0101_0101);
            rs2       = 32'(sent + 7);
            in_tag    = 5'(sent + 8);
            #1;
            if (held) begin
                n_vec++; if (out_valid !== 1'b1 || rd !== prev_rd || out_tag !== prev_tag) begin n_err++;
                    $display("FAIL stall_hold got v=%b rd=%h tag=%0d want v=1 rd=%h tag=%0d", out_valid, rd, out_tag, prev_rd, prev_tag); end
            end
            if (out_valid && !out_ready) begin
                n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
            end
            held     = out_valid && !out_ready;
            prev_rd  = rd;
            prev_tag = out_tag;
            if (out_valid && out_ready) begin
                if (q_rd.size() == 0) begin
                    n_vec++; n_err++; $display("FAIL stall_extra_result got tag %0d want none", out_tag);
                end else begin
                    er = q_rd.pop_front();
                    et = q_tag.pop_front();
                    n_vec++; if (rd !== er) begin n_err++; $display("FAIL stall_rd[%0d] got %h want %h", recv, rd, er); end
                    n_vec++; if (out_tag !== et) begin n_err++; $display("FAIL stall_tag[%0d] got %0d want %0d", recv, out_tag, et); end
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                q_rd.push_back(model(in_op, rs1, rs2));
                q_tag.push_back(in_tag);
                sent++;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_vec++; if (recv != 12 || q_rd.size() != 0) begin n_err++; $display("FAIL stall_count got %0d left %0d want 12 left 0", recv, q_rd.size()); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_drain got %b want 0", out_valid); end
    endtask

    task automatic test_flush;
        logic [31:0] res;
        logic [4:0]  t;
        int          lat;
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 2'd0; rs1 = 32'h1; rs2 = 32'd4; in_tag = 5'd1;
        @(negedge clk);
        in_op = 2'd1; rs1 = 32'hF0; rs2 = 32'd4; in_tag = 5'd2;
        @(negedge clk);
        flush = 1'b1; in_op = 2'd3; rs1 = 32'h3; rs2 = 32'd1; in_tag = 5'd3;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_leak[%0d] got %b want 0", i, out_valid); end
        end
        // Flush while stalled with a full pipe.
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 2'd0; rs1 = 32'h5; rs2 = 32'd1; in_tag = 5'd4;
        @(negedge clk);
        in_tag = 5'd5;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_stall got %b want 0", out_valid); end
        do_op(2'd2, 32'h8421_0000, 32'd8, 5'd9, res, t, lat);
        n_vec++; if (res !== 32'hFF84_2100) begin n_err++; $display("FAIL flush_next_rd got %h want ff842100", res); end
        n_vec++; if (t !== 5'd9) begin n_err++; $display("FAIL flush_next_tag got %0d want 9", t); end
        n_vec++; if (lat != c_p) begin n_err++; $display("FAIL flush_next_latency got %0d want %0d", lat, c_p); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] res;
        logic [4:0]  t;
        int          lat;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_op = 2'd0; rs1 = 32'h0000_0F0F; rs2 = 32'(k + 1); in_tag = 5'(11 + k);
            @(negedge clk);
        end
        rst_n = 1'b0; in_tag = 5'd14;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_reset_in_ready got %b want 0", in_ready); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_valid got %b want 0", out_valid); end
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL mid_reset_rd got %h want 00000000", rd); end
        n_vec++; if (out_tag !== 5'h0) begin n_err++; $display("FAIL mid_reset_tag got %0d want 0", out_tag); end
        rst_n = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_leak[%0d] got %b want 0", i, out_valid); end
        end
        do_op(2'd3, 32'h0000_00F1, 32'd4, 5'd21, res, t, lat);
        n_vec++; if (res !== 32'h1000_000F) begin n_err++; $display("FAIL mid_reset_next_rd got %h want 1000000f", res); end
        n_vec++; if (t !== 5'd21) begin n_err++; $display("FAIL mid_reset_next_tag got %0d want 21", t); end
    endtask

    task automatic test_random;
        logic [31:0] res;
        logic [4:0]  t;
        int          lat;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            do_op(op, a, b, 5'(i), res, t, lat);
            n_vec++; if (res !== model(op, a, b)) begin n_err++;
                $display("FAIL rand_rd[%0d] op=%0d a=%h b=%h got %h want %h", i, op, a, b, res, model(op, a, b)); end
            n_vec++; if (t !== 5'(i) || lat != c_p) begin n_err++;
                $display("FAIL rand_tag_lat[%0d] got tag=%0d lat=%0d want tag=%0d lat=%0d", i, t, lat, i, c_p); end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'd0;
        rs1       = '0;
        rs2       = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        test_reset();
        test_fill();
        test_zero_shamt();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pipelined_barrel_shifter
`default_nettype wire
